// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipeline: frame-buffer address generation, pixel expansion, sync alignment, double-buffer swap.
// Optional colour-bar generator compiled in with `define TEST_PATTERN_EN.
module vga_pixel_pipe #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned VERT_PIXELS = 768
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [11:0] pix_row,
  input  logic [11:0] pix_col,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        vid_on_in,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        disp_buf,
  output logic [16:0] mem_addr,
  output logic        mem_en,
  input  logic [7:0]  mem_data,
  input  logic        test_mode,
  output logic        hs_out,
  output logic        vs_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned CNT_W       = 12;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned ADDR_W      = 1 + 2 * IDX_W;
  localparam int unsigned RGB_W       = 12;
  localparam int unsigned HORZ_PIXELS = 1024;
  localparam int unsigned LATENCY     = MEM_LATENCY + 2;
  // Syncs already lag the counters by one cycle; video_on is consumed one stage before rgb_out.
  localparam int unsigned SYNC_DEPTH  = LATENCY - 1;
  localparam int unsigned VID_DEPTH   = LATENCY - 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_disp_buf;
  logic                w_disp_buf_nxt;
  logic                r_swap_ack;
  logic                w_swap_ack_nxt;
  logic                w_blank_start;

  logic                w_active;
  logic                w_mem_en_nxt;
  logic [IDX_W-1:0]    w_row_idx;
  logic [IDX_W-1:0]    w_col_idx;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_en;

  logic [SYNC_DEPTH-1:0] r_hs_pipe;
  logic [SYNC_DEPTH-1:0] r_vs_pipe;
  logic [VID_DEPTH-1:0]  r_vid_pipe;

  logic [2:0]          w_r;
  logic [2:0]          w_g;
  logic [1:0]          w_b;
  logic [RGB_W-1:0]    w_expanded;
  logic [RGB_W-1:0]    w_pixel;
  logic [RGB_W-1:0]    r_rgb;

  // Stage A: active-area decode and scaled frame-buffer address.
  always_comb begin
    w_active  = (pix_col < CNT_W'(HORZ_PIXELS)) && (pix_row < CNT_W'(VERT_PIXELS));
    w_row_idx = IDX_W'(pix_row >> SCALE_SHIFT);
    w_col_idx = IDX_W'(pix_col >> SCALE_SHIFT);
`ifdef TEST_PATTERN_EN
    w_mem_en_nxt = w_active & ~test_mode;
`else
    w_mem_en_nxt = w_active;
`endif
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_mem_en   <= 1'b0;
    end else begin
      r_mem_addr <= {r_disp_buf, w_row_idx, w_col_idx};
      r_mem_en   <= w_mem_en_nxt;
    end
  end

  // Sync / video_on delay lines matching the address-memory-colour path.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_hs_pipe  <= '1;
      r_vs_pipe  <= '1;
      r_vid_pipe <= '0;
    end else begin
      r_hs_pipe[0]  <= hs_in;
      r_vs_pipe[0]  <= vs_in;
      r_vid_pipe[0] <= vid_on_in;
      for (int i = 1; i < int'(SYNC_DEPTH); i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
      for (int i = 1; i < int'(VID_DEPTH); i++) begin
        r_vid_pipe[i] <= r_vid_pipe[i-1];
      end
    end
  end

  // RRRGGGBB to 4:4:4 by bit replication so full-scale stays full-scale.
  always_comb begin
    w_r        = mem_data[7:5];
    w_g        = mem_data[4:2];
    w_b        = mem_data[1:0];
    w_expanded = {w_r, w_r[2], w_g, w_g[2], w_b, w_b};
  end

`ifdef TEST_PATTERN_EN
  logic [2:0]       r_bar_pipe [SYNC_DEPTH];
  logic [2:0]       w_bar;
  logic [RGB_W-1:0] w_bar_rgb;

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_DEPTH); i++) begin
        r_bar_pipe[i] <= 3'd0;
      end
    end else begin
      r_bar_pipe[0] <= pix_col[9:7];
      for (int i = 1; i < int'(SYNC_DEPTH); i++) begin
        r_bar_pipe[i] <= r_bar_pipe[i-1];
      end
    end
  end

  always_comb begin
    w_bar     = r_bar_pipe[SYNC_DEPTH-1];
    w_bar_rgb = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
    w_pixel   = test_mode ? w_bar_rgb : w_expanded;
  end
`else
  logic w_unused_test_mode;

  always_comb begin
    w_unused_test_mode = test_mode;
    w_pixel            = w_expanded;
  end
`endif

  // Stage C: blanking forces black regardless of what memory returned.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= r_vid_pipe[VID_DEPTH-1] ? w_pixel : '0;
    end
  end

  // Swap FSM: a request is held until the first cycle of vertical blanking.
  always_comb begin
    w_blank_start = (pix_row == CNT_W'(VERT_PIXELS)) && (pix_col == CNT_W'(0));
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_disp_buf <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_disp_buf <= w_disp_buf_nxt;
      r_swap_ack <= w_swap_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_disp_buf_nxt = r_disp_buf;
    w_swap_ack_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (swap_req) begin
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (w_blank_start) begin
          w_state_nxt    = S_IDLE;
          w_disp_buf_nxt = ~r_disp_buf;
          w_swap_ack_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_addr = r_mem_addr;
  assign mem_en   = r_mem_en;
  assign hs_out   = r_hs_pipe[SYNC_DEPTH-1];
  assign vs_out   = r_vs_pipe[SYNC_DEPTH-1];
  assign rgb_out  = r_rgb;
  assign disp_buf = r_disp_buf;
  assign swap_ack = r_swap_ack;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe: driver queues expected outputs with a due cycle, monitor compares.
module tb_vga_pixel_pipe;

  localparam int L = 4;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pix_row = '0;
  logic [11:0] pix_col = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        vid_on_in = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        disp_buf;
  logic [16:0] mem_addr;
  logic        mem_en;
  logic [7:0]  mem_data;
  logic        test_mode = 1'b0;
  logic        hs_out;
  logic        vs_out;
  logic [11:0] rgb_out;

  vga_pixel_pipe #(.MEM_LATENCY(2), .SCALE_SHIFT(2), .VERT_PIXELS(768)) dut (
    .clock(clock), .rst(rst), .pix_row(pix_row), .pix_col(pix_col),
    .hs_in(hs_in), .vs_in(vs_in), .vid_on_in(vid_on_in),
    .swap_req(swap_req), .swap_ack(swap_ack), .disp_buf(disp_buf),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .test_mode(test_mode), .hs_out(hs_out), .vs_out(vs_out), .rgb_out(rgb_out)
  );

  always #5 clock = ~clock;

  // Two-cycle memory returning the low address byte.
  logic [7:0] m1, m2;
  always @(posedge clock) begin
    m1 <= mem_addr[7:0];
    m2 <= m1;
  end
  assign mem_data = m2;

  int cyc = 0;
  always @(posedge clock) cyc++;

  localparam int S_RGB = 0, S_HS = 1, S_VS = 2, S_MEN = 3, S_ADDR = 4, S_DBUF = 5, S_ACK = 6;
  string names [7] = '{"rgb_out", "hs_out", "vs_out", "mem_en", "mem_addr", "disp_buf", "swap_ack"};

  typedef struct {
    int          due;
    int          sel;
    logic [16:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   track = 1'b0;
  bit   prev_hs = 1'b1, prev_vs = 1'b1, prev_vid = 1'b0;
  logic exp_buf = 1'b0;

  function automatic logic [16:0] actual(input int sel);
    case (sel)
      S_RGB:   return 17'(rgb_out);
      S_HS:    return 17'(hs_out);
      S_VS:    return 17'(vs_out);
      S_MEN:   return 17'(mem_en);
      S_ADDR:  return mem_addr;
      S_DBUF:  return 17'(disp_buf);
      default: return 17'(swap_ack);
    endcase
  endfunction

  function automatic logic [11:0] model_pix(input int c);
    logic [7:0] d;
    d = 8'((c >> 2) & 255);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  function automatic logic [11:0] model_bar(input int c);
    logic [2:0] k;
    k = 3'((c >> 7) & 7);
    return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
  endfunction

  task automatic push(input int due, input int sel, input logic [16:0] val);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic chk(input int sel, input logic [16:0] val);
    push(cyc, sel, val);
  endtask

  // One generator cycle: counters now, syncs/video_on for the previous counter.
  task automatic drive(input int r, input int c, input bit sreq = 1'b0,
                       input bit use_lit = 1'b0, input logic [11:0] lit = 12'h0);
    bit cur_vid, tp;
    pix_row   = 12'(r);
    pix_col   = 12'(c);
    swap_req  = sreq;
    hs_in     = prev_hs;
    vs_in     = prev_vs;
    vid_on_in = prev_vid;
    cur_vid   = (c < 1024) && (r < 768);
    tp        = 1'b0;
`ifdef TEST_PATTERN_EN
    tp        = test_mode;
`endif
    if (track) begin
      push(cyc + L, S_RGB, 17'(!cur_vid ? 12'h000 : (tp ? model_bar(c) : model_pix(c))));
      if (use_lit) push(cyc + L, S_RGB, 17'(lit));
      push(cyc + 1, S_MEN, 17'(cur_vid && !tp));
      push(cyc + 1, S_ADDR, {exp_buf, 8'((r >> 2) & 255), 8'((c >> 2) & 255)});
      push(cyc + L - 1, S_HS, 17'(prev_hs));
      push(cyc + L - 1, S_VS, 17'(prev_vs));
    end
    prev_hs  = !(c >= 1048 && c < 1184);
    prev_vs  = !(r >= 771 && r < 777);
    prev_vid = cur_vid;
    @(posedge clock);
    #1;
  endtask

  task automatic quiesce();
    track = 1'b0;
    for (int i = 0; i < L + 1; i++) drive(780, 1200);
    track = 1'b1;
  endtask

  always @(negedge clock) begin
    for (int i = int'(q.size()) - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        logic [16:0] a;
        a = actual(q[i].sel);
        n_cmp++;
        if (q[i].due < cyc || a !== q[i].val) begin
          n_err++;
          $display("FAIL %s due=%0d cyc=%0d got %h expected %h",
                   names[q[i].sel], q[i].due, cyc, a, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    // Reset with syncs held low at the inputs: outputs must still show reset values.
    rst = 1'b1;
    for (int i = 0; i < 6; i++) drive(772, 1100);
    chk(S_HS, 17'(1)); chk(S_VS, 17'(1)); chk(S_RGB, 17'(0));
    chk(S_MEN, 17'(0)); chk(S_ADDR, 17'(0)); chk(S_DBUF, 17'(0)); chk(S_ACK, 17'(0));
    rst = 1'b0;
    drive(0, 0);
    track = 1'b1;

    // Latency and expansion, then horizontal blanking with nonzero memory data.
    drive(0, 0);
    drive(0, 4, 0, 1, 12'h005);
    drive(0, 256, 0, 1, 12'h400);
    drive(3, 1020, 0, 1, 12'hFFF);
    drive(5, 500);
    drive(767, 1023);
    drive(0, 1024, 0, 1, 12'h000);
    drive(0, 1100, 0, 1, 12'h000);
    drive(0, 1327, 0, 1, 12'h000);

    // Hsync falling and rising edges.
    for (int c = 1044; c < 1053; c++) drive(20, c);
    for (int c = 1180; c < 1189; c++) drive(20, c);

    // Vertical blanking region including an idle blank-start cycle.
    for (int r = 765; r < 780; r++) drive(r, 0);
    chk(S_ACK, 17'(0)); chk(S_DBUF, 17'(0));
    drive(805, 1327);

    // Mid-frame request, duplicate ignored, applied only at blank start.
    drive(100, 0, 1);
    chk(S_DBUF, 17'(0));
    drive(150, 500);
    drive(200, 10, 1);
    drive(767, 1023);
    chk(S_ACK, 17'(0)); chk(S_DBUF, 17'(0));
    drive(768, 0);
    chk(S_ACK, 17'(1)); chk(S_DBUF, 17'(1));
    exp_buf = 1'b1;
    drive(768, 1);
    chk(S_ACK, 17'(0)); chk(S_DBUF, 17'(1));
    drive(50, 40);

    // Request on the blank-start cycle itself waits a full frame.
    drive(768, 0, 1);
    chk(S_ACK, 17'(0)); chk(S_DBUF, 17'(1));
    drive(769, 0);
    drive(800, 0);
    drive(0, 0);
    drive(400, 400);
    drive(768, 0);
    chk(S_ACK, 17'(1)); chk(S_DBUF, 17'(0));
    exp_buf = 1'b0;
    drive(770, 0);

    // Back to buffer 1, then reset while a swap is pending.
    drive(10, 0, 1);
    drive(768, 0);
    chk(S_ACK, 17'(1)); chk(S_DBUF, 17'(1));
    exp_buf = 1'b1;
    drive(300, 0, 1);
    chk(S_DBUF, 17'(1));
    drive(400, 0);
    track = 1'b0;
    for (int i = 0; i < L + 1; i++) drive(450, 1100);
    rst = 1'b1;
    drive(500, 0);
    drive(500, 1100);
    chk(S_DBUF, 17'(0)); chk(S_ACK, 17'(0)); chk(S_HS, 17'(1));
    chk(S_VS, 17'(1)); chk(S_RGB, 17'(0)); chk(S_MEN, 17'(0));
    rst = 1'b0;
    exp_buf = 1'b0;
    drive(501, 0);
    track = 1'b1;
    drive(600, 8);
    drive(768, 0);
    chk(S_ACK, 17'(0)); chk(S_DBUF, 17'(0));
    drive(768, 1);
    chk(S_ACK, 17'(0)); chk(S_DBUF, 17'(0));

    // Test-pattern select: bars when compiled in, otherwise ignored.
    quiesce();
    test_mode = 1'b1;
    quiesce();
`ifdef TEST_PATTERN_EN
    drive(10, 384, 0, 1, 12'h0FF);
`else
    drive(10, 384, 0, 1, 12'h600);
`endif
    drive(10, 900);
    drive(10, 1100);
    quiesce();
    test_mode = 1'b0;
    quiesce();

    drive(780, 0);
    drive(780, 500);
    drive(805, 1023);
    drive(0, 12);
    track = 1'b0;
    for (int i = 0; i < L + 2; i++) drive(780, 1200);

    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain left %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
